// File: rtl/vram_hdma.sv
// ---------------------------------------------------------------------------
// vram_hdma - GBC HDMA controller (registers FF51-FF55)
//
// Copies data from the CPU address space into VRAM, one byte per two ce
// phases (read phase, then write phase). Two modes:
//   GDMA : all requested blocks are copied back to back.
//   HDMA : one BLOCK_BYTES block per HBlank entry.
// The CPU is stalled (hdma_active) only while bytes actually move.
//
// Ports:
//   clk_sys, reset_n         system clock, async active-low reset
//   ce                       transfer step enable (one byte phase per ce)
//   cpu_ce, cpu_sel_reg,
//   cpu_addr, cpu_wr, cpu_di CPU register bus (write side)
//   cpu_do                   CPU register read data
//   isGBC                    0 disables the block and aborts transfers
//   lcd_on, lcd_mode         video state used to detect HBlank entry
//   vram_bank                selects vram_wren (0) or vram1_wren (1)
//   hdma_active              CPU stall request, high in RD/WR only
//   src_addr, src_rd         source read request
//   src_data                 source data, valid one ce after src_rd
//   vram_addr, vram_di       VRAM write address/data
//   vram_wren, vram1_wren    bank-0 / bank-1 write strobes
// ---------------------------------------------------------------------------
module vram_hdma #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        cpu_ce,
  input  logic        isGBC,
  input  logic        cpu_sel_reg,
  input  logic [7:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic        lcd_on,
  input  logic [1:0]  lcd_mode,
  input  logic        vram_bank,
  output logic        hdma_active,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_di,
  output logic        vram_wren,
  output logic        vram1_wren
);

  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
  // Address bits below the block size are always zero in the shadow registers.
  localparam logic [7:0]    LOW_MASK  = 8'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HWAIT = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next;

  logic [15:0]     src_sh_r;         // FF51/FF52 shadow
  logic [12:0]     dst_sh_r;         // FF53/FF54 shadow
  logic [15:0]     src_w_r;          // working source address
  logic [12:0]     dst_w_r;          // working destination address
  logic [6:0]      len_r;            // remaining blocks - 1
  logic            busy_r;           // transfer armed or running
  logic            hdma_mode_r;      // 1 = HBlank mode, 0 = general purpose
  logic            cancel_pending_r; // HDMA cancel requested mid-block
  logic [BW-1:0]   byte_cnt_r;
  logic [1:0]      prev_mode_r;

  logic            reg_wr_s;
  logic            wr55_s;
  logic            hdma_run_s;
  logic            cancel_s;
  logic            restart_s;
  logic            hblank_edge_s;
  logic            rd_step_s;
  logic            wr_step_s;
  logic            block_end_s;

  assign reg_wr_s      = cpu_ce && cpu_sel_reg && cpu_wr && isGBC;
  assign wr55_s        = reg_wr_s && (cpu_addr == 8'h55);
  // FF55 writes only cancel/restart an HDMA that is armed or running;
  // during GDMA the CPU is stalled so such writes are ignored.
  assign hdma_run_s    = hdma_mode_r && (state_r != IDLE);
  assign cancel_s      = wr55_s && !cpu_di[7] && hdma_run_s;
  assign restart_s     = wr55_s &&  cpu_di[7] && hdma_run_s;
  // HBlank entry: mode changes from non-00 to 00 while the LCD is on.
  assign hblank_edge_s = lcd_on && (lcd_mode == 2'b00) && (prev_mode_r != 2'b00);
  assign rd_step_s     = (state_r == RD) && ce && isGBC;
  assign wr_step_s     = (state_r == WR) && ce && isGBC;
  assign block_end_s   = wr_step_s && (byte_cnt_r == LAST_BYTE);

  // Strobes are combinational from the registered state so they coincide
  // with ce and vanish the moment reset is asserted.
  assign hdma_active = (state_r == RD) || (state_r == WR);
  assign src_rd      = rd_step_s;
  assign src_addr    = src_w_r;
  assign vram_addr   = dst_w_r;
  assign vram_di     = src_data;
  assign vram_wren   = wr_step_s && !vram_bank;
  assign vram1_wren  = wr_step_s &&  vram_bank;

  // Register read mux: only FF55 is readable.
  always_comb begin
    cpu_do = 8'hFF;
    if (isGBC && (cpu_addr == 8'h55)) begin
      cpu_do = {~busy_r, len_r};
    end else begin
      cpu_do = 8'hFF;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    if (!isGBC) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr55_s) begin
            // HDMA with the LCD off moves its first block immediately.
            if (cpu_di[7] && lcd_on) begin
              state_next = HWAIT;
            end else begin
              state_next = RD;
            end
          end else begin
            state_next = IDLE;
          end
        end
        HWAIT: begin
          if (cancel_s) begin
            state_next = IDLE;
          end else if (hblank_edge_s) begin
            state_next = RD;
          end else begin
            state_next = HWAIT;
          end
        end
        RD: begin
          if (ce) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
        WR: begin
          if (!ce) begin
            state_next = WR;
          end else if (!block_end_s) begin
            state_next = RD;
          end else if ((len_r == 7'd0) && !restart_s) begin
            state_next = IDLE;
          end else if (!hdma_mode_r) begin
            state_next = RD;
          end else if (cancel_pending_r || cancel_s) begin
            state_next = IDLE;
          end else begin
            state_next = HWAIT;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Previous video mode, for HBlank entry detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_mode_r <= 2'b00;
    end else begin
      prev_mode_r <= lcd_mode;
    end
  end

  // Shadow registers, working counters and transfer bookkeeping.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      src_sh_r         <= 16'h0000;
      dst_sh_r         <= 13'h0000;
      src_w_r          <= 16'h0000;
      dst_w_r          <= 13'h0000;
      len_r            <= 7'h7F;
      busy_r           <= 1'b0;
      hdma_mode_r      <= 1'b0;
      cancel_pending_r <= 1'b0;
      byte_cnt_r       <= '0;
    end else if (!isGBC) begin
      busy_r           <= 1'b0;
      cancel_pending_r <= 1'b0;
    end else begin
      if (reg_wr_s) begin
        case (cpu_addr)
          8'h51:   src_sh_r[15:8] <= cpu_di;
          8'h52:   src_sh_r[7:0]  <= cpu_di & ~LOW_MASK;
          8'h53:   dst_sh_r[12:8] <= cpu_di[4:0];
          8'h54:   dst_sh_r[7:0]  <= cpu_di & ~LOW_MASK;
          default: ;
        endcase
      end

      if (state_r == IDLE) begin
        if (wr55_s) begin
          len_r            <= cpu_di[6:0];
          busy_r           <= 1'b1;
          hdma_mode_r      <= cpu_di[7];
          cancel_pending_r <= 1'b0;
          src_w_r          <= src_sh_r;
          dst_w_r          <= dst_sh_r;
          byte_cnt_r       <= '0;
        end
      end else begin
        // Restart keeps the working addresses and reloads only the length.
        if (restart_s) begin
          len_r            <= cpu_di[6:0];
          busy_r           <= 1'b1;
          cancel_pending_r <= 1'b0;
        end
        if (cancel_s) begin
          if (state_r == HWAIT) begin
            busy_r <= 1'b0;
          end else begin
            cancel_pending_r <= 1'b1;
          end
        end
        if (wr_step_s) begin
          src_w_r    <= src_w_r + 16'd1;
          dst_w_r    <= dst_w_r + 13'd1;
          byte_cnt_r <= byte_cnt_r + BW'(1);
          // A restart landing on the block end wins over the decrement.
          if (block_end_s && !restart_s) begin
            len_r <= len_r - 7'd1;   // 0 wraps to 7F: FF55 then reads FF
            if (len_r == 7'd0) begin
              busy_r           <= 1'b0;
              cancel_pending_r <= 1'b0;
            end else if (hdma_mode_r && (cancel_pending_r || cancel_s)) begin
              busy_r           <= 1'b0;
              cancel_pending_r <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_hdma.sv
// ---------------------------------------------------------------------------
// tb_vram_hdma - self-checking bench for vram_hdma.
// Source memory is a random 64 KiB array; every VRAM write observed is
// compared against a queue of expected writes built from the register
// values with plain address arithmetic.
// ---------------------------------------------------------------------------
module tb_vram_hdma;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce = 1'b0;
  logic        cpu_ce;
  logic        isGBC;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        lcd_on;
  logic [1:0]  lcd_mode;
  logic        vram_bank;
  logic        hdma_active;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data = 8'h00;
  logic [12:0] vram_addr;
  logic [7:0]  vram_di;
  logic        vram_wren;
  logic        vram1_wren;

  int checks = 0;
  int errors = 0;
  int act_ce = 0;

  logic [7:0]  mem [0:65535];
  // write record: {vram_wren, vram1_wren, addr[12:0], data[7:0]}
  logic [22:0] obs[$];
  logic [22:0] exp_q[$];

  vram_hdma #(.BLOCK_BYTES(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .cpu_ce(cpu_ce),
    .isGBC(isGBC), .cpu_sel_reg(cpu_sel_reg), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .lcd_on(lcd_on),
    .lcd_mode(lcd_mode), .vram_bank(vram_bank), .hdma_active(hdma_active),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
    .vram_addr(vram_addr), .vram_di(vram_di), .vram_wren(vram_wren),
    .vram1_wren(vram1_wren)
  );

  always #5 clk_sys = ~clk_sys;

  // Random ce, roughly 3 of 4 cycles, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      ce = ($urandom_range(0, 3) != 0);
    end
  end

  // Source memory responder and write monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (src_rd) src_data = mem[src_addr];
      if (vram_wren || vram1_wren) obs.push_back({vram_wren, vram1_wren, vram_addr, vram_di});
      if (hdma_active && ce) act_ce++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected writes: n bytes from s onwards into d onwards, both wrapping.
  task automatic expect_copy(input logic [15:0] s, input logic [12:0] d, input int n, input logic bank);
    for (int i = 0; i < n; i++) exp_q.push_back({~bank, bank, 13'(d + i), mem[16'(s + i)]});
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk_sys); #2;
    cpu_ce = 1'b1; cpu_sel_reg = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
    @(posedge clk_sys); #2;
    cpu_ce = 1'b0; cpu_sel_reg = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk_sys); #2;
    cpu_addr = a; cpu_sel_reg = 1'b1;
    #1 d = cpu_do;
    cpu_sel_reg = 1'b0;
  endtask

  task automatic wait_xfer(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_sys); #1;
      if (obs.size() >= n && !hdma_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    #1 reset_n = 1'b0;
    #20;
    checks++;
    if ({hdma_active, src_rd, vram_wren, vram1_wren} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {hdma_active, src_rd, vram_wren, vram1_wren});
    end
    repeat (2) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    reg_rd(8'h55, r);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL reset_ff55 got %h want ff", r); end
    reg_rd(8'h51, r);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL reset_ff51 got %h want ff", r); end
    isGBC = 1'b0;
    reg_rd(8'h55, r);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL nogbc_ff55 got %h want ff", r); end
    isGBC = 1'b1;
  endtask

  task automatic test_gdma();
    logic [7:0] sh, sl, dh, dl, ln, r;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        sh = 8'hC0; sl = 8'h00; dh = 8'h00; dl = 8'h00; ln = 8'h01;
      end else begin
        sh = 8'($urandom_range(0, 255)); sl = 8'($urandom_range(0, 255));
        dh = 8'($urandom_range(0, 255)); dl = 8'($urandom_range(0, 255));
        ln = 8'($urandom_range(0, 3));
      end
      reg_wr(8'h51, sh); reg_wr(8'h52, sl); reg_wr(8'h53, dh); reg_wr(8'h54, dl);
      obs.delete(); exp_q.delete();
      expect_copy({sh, sl & 8'hF0}, {dh[4:0], dl & 8'hF0}, (int'(ln) + 1) * 16, 1'b0);
      act_ce = 0;
      reg_wr(8'h55, ln);
      wait_xfer(exp_q.size(), 3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gdma_timeout got %0d writes want %0d", obs.size(), exp_q.size()); end
      checks++;
      if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL gdma_count got %0d want %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL gdma_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
      end
      checks++;
      if (act_ce !== exp_q.size() * 2) begin errors++; $display("FAIL gdma_active_ce got %0d want %0d", act_ce, exp_q.size() * 2); end
      reg_rd(8'h55, r);
      checks++;
      if (r !== 8'hFF) begin errors++; $display("FAIL gdma_ff55 got %h want ff", r); end
    end
  endtask

  task automatic test_hdma();
    logic [7:0] sh, sl, dh, dl, r;
    logic [15:0] s;
    logic [12:0] d;
    bit ok;
    sh = 8'($urandom_range(0, 255)); sl = 8'($urandom_range(0, 255));
    dh = 8'($urandom_range(0, 255)); dl = 8'($urandom_range(0, 255));
    s = {sh, sl & 8'hF0}; d = {dh[4:0], dl & 8'hF0};
    reg_wr(8'h51, sh); reg_wr(8'h52, sl); reg_wr(8'h53, dh); reg_wr(8'h54, dl);
    lcd_on = 1'b1; lcd_mode = 2'b11;
    obs.delete(); exp_q.delete();
    reg_wr(8'h55, 8'h81);
    repeat (20) @(posedge clk_sys);
    #2;
    checks++;
    if (hdma_active !== 1'b0 || obs.size() !== 0) begin
      errors++; $display("FAIL hdma_armed_idle got active=%b writes=%0d want 0/0", hdma_active, obs.size());
    end
    for (int blk = 0; blk < 3; blk++) begin
      lcd_mode = 2'b00;
      if (blk < 2) begin
        expect_copy(16'(s + blk * 16), 13'(d + blk * 16), 16, 1'b0);
        wait_xfer(exp_q.size(), 2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hdma_timeout blk %0d got %0d writes", blk, obs.size()); end
      end else begin
        repeat (200) @(posedge clk_sys);
      end
      repeat (10) @(posedge clk_sys);
      #2;
      checks++;
      if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL hdma_count blk %0d got %0d want %0d", blk, obs.size(), exp_q.size()); end
      checks++;
      if (hdma_active !== 1'b0) begin errors++; $display("FAIL hdma_gap_active blk %0d got %b want 0", blk, hdma_active); end
      reg_rd(8'h55, r);
      checks++;
      if (r !== ((blk == 0) ? 8'h00 : 8'hFF)) begin
        errors++; $display("FAIL hdma_ff55 blk %0d got %h want %h", blk, r, (blk == 0) ? 8'h00 : 8'hFF);
      end
      lcd_mode = 2'b10;
      repeat (5) @(posedge clk_sys);
      #2;
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL hdma_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_cancel();
    logic [7:0] r;
    bit ok;
    reg_wr(8'h51, 8'h40); reg_wr(8'h52, 8'h30); reg_wr(8'h53, 8'h05); reg_wr(8'h54, 8'h60);
    lcd_on = 1'b1; lcd_mode = 2'b11;
    obs.delete(); exp_q.delete();
    expect_copy(16'h4030, 13'h0560, 16, 1'b0);
    reg_wr(8'h55, 8'h83);
    lcd_mode = 2'b00;
    wait_xfer(16, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cancel_timeout got %0d writes want 16", obs.size()); end
    reg_rd(8'h55, r);
    checks++;
    if (r !== 8'h02) begin errors++; $display("FAIL cancel_ff55_active got %h want 02", r); end
    lcd_mode = 2'b11;
    reg_wr(8'h55, 8'h03);
    reg_rd(8'h55, r);
    checks++;
    if (r !== 8'h82) begin errors++; $display("FAIL cancel_ff55 got %h want 82", r); end
    lcd_mode = 2'b00;
    repeat (200) @(posedge clk_sys);
    #2;
    checks++;
    if (obs.size() !== 16) begin errors++; $display("FAIL cancel_count got %0d want 16", obs.size()); end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL cancel_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
    lcd_mode = 2'b11;
  endtask

  task automatic test_wrap();
    bit ok;
    reg_wr(8'h51, 8'hFF); reg_wr(8'h52, 8'hF7); reg_wr(8'h53, 8'hFF); reg_wr(8'h54, 8'hF5);
    obs.delete(); exp_q.delete();
    expect_copy(16'hFFF0, 13'h1FF0, 32, 1'b0);
    reg_wr(8'h55, 8'h01);
    wait_xfer(32, 3000, ok);
    checks++;
    if (!ok || obs.size() !== 32) begin errors++; $display("FAIL wrap_count got %0d want 32", obs.size()); end
    for (int i = 0; i < 32 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_bank();
    logic [7:0] sh, dl, ln;
    bit ok;
    sh = 8'($urandom_range(0, 255)); dl = 8'($urandom_range(0, 255)); ln = 8'($urandom_range(0, 1));
    reg_wr(8'h51, sh); reg_wr(8'h52, 8'h00); reg_wr(8'h53, 8'h1F); reg_wr(8'h54, dl);
    vram_bank = 1'b1;
    obs.delete(); exp_q.delete();
    expect_copy({sh, 8'h00}, {5'h1F, dl & 8'hF0}, (int'(ln) + 1) * 16, 1'b1);
    reg_wr(8'h55, ln);
    wait_xfer(exp_q.size(), 3000, ok);
    checks++;
    if (!ok || obs.size() !== exp_q.size()) begin errors++; $display("FAIL bank_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL bank_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
    vram_bank = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    bit ok;
    reg_wr(8'h51, 8'h12); reg_wr(8'h52, 8'h30); reg_wr(8'h53, 8'h02); reg_wr(8'h54, 8'h40);
    obs.delete(); exp_q.delete();
    expect_copy(16'h1230, 13'h0240, 5, 1'b0);
    reg_wr(8'h55, 8'h03);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_sys);
      #1;
      if (obs.size() >= 5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d writes want 5", obs.size()); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({hdma_active, src_rd, vram_wren, vram1_wren} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_strobes got %b want 0000", {hdma_active, src_rd, vram_wren, vram1_wren});
    end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_write[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
    repeat (3) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    reg_rd(8'h55, r);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL rstmid_ff55 got %h want ff", r); end
    obs.delete();
    repeat (300) @(posedge clk_sys);
    #2;
    checks++;
    if (obs.size() !== 0 || hdma_active !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got writes=%0d active=%b want 0/0", obs.size(), hdma_active);
    end
  endtask

  initial begin
    reset_n = 1'b1; cpu_ce = 1'b0; isGBC = 1'b1; cpu_sel_reg = 1'b0;
    cpu_addr = 8'h00; cpu_wr = 1'b0; cpu_di = 8'h00;
    lcd_on = 1'b1; lcd_mode = 2'b11; vram_bank = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_gdma();
    test_hdma();
    test_cancel();
    test_wrap();
    test_bank();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_hdma.md
Name: vram_hdma

Overview:
- GBC HDMA controller (registers FF51–FF55).
- Sequences copies from the CPU address space into VRAM through the VRAM write port (vram_addr/vram_di/vram_wren/vram1_wren).
- Supports general-purpose DMA (GDMA: all blocks back to back) and HBlank DMA (HDMA: one 16-byte block per HBlank).
- Stalls the CPU while bytes move; sits between the CPU register bus, the external memory mux and the VRAM arrays.

Parameters:
- BLOCK_BYTES, 16, bytes per block. Must be a power of two; address low bits masked accordingly.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  transfer step enable (one byte phase per ce)
- cpu_ce  in  1  register-access qualifier
- isGBC  in  1  0 = block disabled
- cpu_sel_reg  in  1  CPU register select
- cpu_addr  in  8  register address low byte
- cpu_wr  in  1  register write strobe
- cpu_di  in  8  register write data
- cpu_do  out  8  register read data
- lcd_on  in  1  LCD enabled
- lcd_mode  in  2  video mode (00 = HBlank)
- vram_bank  in  1  current VBK bank
- hdma_active  out  1  CPU stall request
- src_addr  out  16  source read address
- src_rd  out  1  source read strobe
- src_data  in  8  source data, valid one ce after src_rd
- vram_addr  out  13  VRAM destination address
- vram_di  out  8  VRAM write data
- vram_wren  out  1  bank-0 write
- vram1_wren  out  1  bank-1 write

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; all strobes 0; hdma_active 0.
  - src 16'h0000; dst 13'h0000; len 7'h7F.
  - done flag 1, so FF55 reads 8'hFF.
- Register writes (clk_sys edge with cpu_ce & cpu_sel_reg & cpu_wr & isGBC):
  - 51: src[15:8].
  - 52: src[7:4]; low nibble forced 0.
  - 53: dst[12:8] from cpu_di[4:0].
  - 54: dst[7:4]; low nibble forced 0.
  - 55: see FF55 handling below.
- Register reads: cpu_do = FF for 51–54, for any unmapped address, and when isGBC=0.
- FF55 read: {~busy_or_cancelled_flag, remaining−1}.
  - Active: bit7=0, low 7 bits = remaining blocks − 1.
  - Completed: 8'hFF.
  - Cancelled: {1, remaining−1 at cancel}.
- FF55 write with bit7=0 while IDLE: start GDMA.
  - len = cpu_di[6:0]; blocks = len+1.
  - Working counters loaded from src/dst; enter RD.
- FF55 write with bit7=1 while IDLE: arm HDMA, enter HWAIT.
- FF55 write with bit7=0 during HDMA (HWAIT or mid-block): cancel.
  - In HWAIT: immediate → IDLE.
  - Mid-block: takes effect after the current block completes.
- FF55 write with bit7=1 during HDMA: restarts HDMA with new len and current working addresses.
- FF51–54 writes during a transfer update shadow registers only; working counters are unaffected.
- States:
  - IDLE.
  - HWAIT: wait for lcd_mode to transition from non-00 to 00 with lcd_on=1.
    - If lcd_on=0 when armed, one block is transferred immediately, then the controller waits for HBlank.
  - RD: on ce, src_rd=1 and src_addr=working src. Go to WR.
  - WR: on ce, vram_di=src_data and vram_addr=working dst; pulse vram_wren if vram_bank=0, else vram1_wren. Then src+1, dst+1, byte_cnt+1.
    - byte_cnt wraps at BLOCK_BYTES → block end: remaining−1.
    - Remaining reaches 0 → IDLE, done.
    - Else GDMA → RD; HDMA → HWAIT (or IDLE if cancel pending).
- Timing: 2 ce per byte, 32 ce per block; strobes are single clk_sys pulses coincident with ce.
- Address wrap: dst wraps 1FFF→0000 within 13 bits; src wraps FFFF→0000.
- hdma_active = 1 in RD/WR only (never in HWAIT or IDLE).
- isGBC=0: starts ignored; any transfer in progress is aborted to IDLE at the next clk_sys edge.
- reset_n asserted mid-block: immediate IDLE, strobes drop in the same cycle.

Test Plan:
- GDMA: src=C000, dst=8000 (FF53=00, FF54=00), FF55←01 → 32 VRAM writes at 0000–001F with data from C000–C01F; hdma_active high 64 ce; FF55 reads FF afterwards.
- HDMA: FF55←81, lcd_on=1, three HBlank entries → 16 writes per HBlank, FF55 reads 00 after the first block, FF after the second; the third HBlank produces no writes; hdma_active low between blocks.
- Cancel: HDMA FF55←83, one block done, then FF55←03 in HWAIT → no further writes; FF55 reads 82.
- Wrap and masking: FF51=FF, FF52=F7, FF53=FF, FF54=F5 → src starts FFF0, dst 1FF0; GDMA len 1 writes 1FF0–1FFF then 0000–000F, with src continuing 0000–000F.
- Bank: vram_bank=1 during GDMA → only vram1_wren pulses, vram_wren stays 0.
- Reset mid-transfer: reset_n=0 at byte 5 → all strobes 0 immediately; FF55 reads FF; no writes after release.
